// File: rtl/ccff_loader.sv
// ccff_loader: streams bitstream words, MSB first, into a serial ccff
// configuration chain and counts the ones returned on the chain tail.
//
// Ports:
//   prog_clk    clock, all state updates on the rising edge
//   pReset      asynchronous active-low reset
//   start       single-cycle request to begin a chain load (ignored in LOAD)
//   in_valid    upstream word valid
//   in_word     upstream bitstream word, MSB shifted first
//   in_ready    loader accepts in_word this cycle
//   ccff_head   serial bit into the chain head
//   ccff_shift  chain shift enable, high when ccff_head carries a valid bit
//   ccff_tail   serial bit returned from the chain tail
//   busy        high while loading
//   done        high once the whole chain has been shifted
//   tail_ones   ones seen on ccff_tail during shift cycles of this/last load
module ccff_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 66,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tail_ones
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BL_W   = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic [BL_W-1:0]    bits_left_q, bits_left_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   tail_ones_q, tail_ones_d;

    logic accept;
    logic last_shift;

    // State register
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (last_shift) state_d = DONE;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state_q == LOAD);
        done       = (state_q == DONE);
        ccff_shift = busy && (bits_left_q != '0);
        ccff_head  = ccff_shift && sreg_q[WORD_W-1];
        // A new word may land on the same edge the last bit of the current
        // one leaves, which keeps the shift stream free of bubbles.
        in_ready   = busy && (word_cnt_q < CNT_W'(NWORDS)) &&
                     ((bits_left_q == '0) ||
                      ((bits_left_q == BL_W'(1)) && ccff_shift));
        tail_ones  = tail_ones_q;
    end

    assign accept     = in_valid && in_ready;
    assign last_shift = ccff_shift && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

    // Datapath next values
    always_comb begin
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        tail_ones_d = tail_ones_q;
        if ((state_q != LOAD) && start) begin
            bits_left_d = '0;
            bit_cnt_d   = '0;
            word_cnt_d  = '0;
            tail_ones_d = '0;
        end else if (state_q == LOAD) begin
            if (ccff_shift) begin
                sreg_d      = {sreg_q[WORD_W-2:0], 1'b0};
                bits_left_d = bits_left_q - BL_W'(1);
                bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                if (ccff_tail && (tail_ones_q != '1))
                    tail_ones_d = tail_ones_q + CNT_W'(1);
            end
            if (accept) begin
                sreg_d      = in_word;
                bits_left_d = BL_W'(WORD_W);
                word_cnt_d  = word_cnt_q + CNT_W'(1);
            end
            // Bits of the final word beyond the chain length are dropped.
            if (last_shift)
                bits_left_d = '0;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sreg_q      <= '0;
            bits_left_q <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            tail_ones_q <= '0;
        end else begin
            sreg_q      <= sreg_d;
            bits_left_q <= bits_left_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            tail_ones_q <= tail_ones_d;
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: default 66-bit chain plus an 8-bit chain.
module tb_ccff_loader;

    logic        prog_clk = 1'b0;
    logic        pReset   = 1'b0;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_word  = 8'h00;
    logic        in_ready, ccff_head, ccff_shift, ccff_tail, busy, done;
    logic [15:0] tail_ones;

    logic        s_start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_word  = 8'h00;
    logic        s_ready, s_head, s_shift, s_busy, s_done;
    logic [15:0] s_tail_ones;

    int ntests = 0;
    int nfail  = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_loader u_dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
        .ccff_head(ccff_head), .ccff_shift(ccff_shift), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .tail_ones(tail_ones)
    );

    ccff_loader #(.WORD_W(8), .CHAIN_LEN(8), .CNT_W(16)) u_dut8 (
        .prog_clk(prog_clk), .pReset(pReset), .start(s_start),
        .in_valid(s_valid), .in_word(s_word), .in_ready(s_ready),
        .ccff_head(s_head), .ccff_shift(s_shift), .ccff_tail(1'b0),
        .busy(s_busy), .done(s_done), .tail_ones(s_tail_ones)
    );

    // Behavioural 66-stage chain driving ccff_tail
    logic [65:0] chain_m = '0;
    logic        preload_en  = 1'b0;
    logic        preload_val = 1'b0;
    always @(posedge prog_clk) begin
        if (preload_en)      chain_m <= {66{preload_val}};
        else if (ccff_shift) chain_m <= {chain_m[64:0], ccff_head};
    end
    assign ccff_tail = chain_m[65];

    logic [7:0]  words [9] = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'hF0, 8'h0F, 8'hC3, 8'h3C, 8'hC0};
    logic [71:0] cat_bits = 72'hFF00AA55F00FC33CC0;
    logic [65:0] exp_bits;

    // Results of the last run_load
    int          r_first, r_last, r_nsh, r_done, r_rdy_late, r_bub;
    logic [65:0] r_bits;
    logic        r_done1, r_busy1;
    logic [15:0] r_tail1;

    task automatic preload(input logic v);
        @(posedge prog_clk); #1;
        preload_val = v;
        preload_en  = 1'b1;
        @(posedge prog_clk); #1;
        preload_en  = 1'b0;
    endtask

    // Start at cycle 0, stream the nine words; gap_len cycles of withheld
    // valid before word index 3, optional extra start at mid_start, and an
    // early return after cycle stop_cyc (inputs left as they were).
    task automatic run_load(input int gap_len, input int mid_start, input int stop_cyc);
        int idx, gapc;
        idx = 0; gapc = 0;
        r_first = -1; r_last = -1; r_nsh = 0; r_done = -1;
        r_rdy_late = 0; r_bub = 0; r_bits = '0;
        r_done1 = 1'b1; r_busy1 = 1'b0; r_tail1 = '1;
        for (int c = 0; c < 120; c++) begin
            @(posedge prog_clk); #1;
            start    = (c == 0) || (c == mid_start);
            in_valid = (idx < 9) && !(idx == 3 && gapc < gap_len);
            in_word  = (idx < 9) ? words[idx] : 8'h00;
            @(negedge prog_clk);
            if (c == 1) begin
                r_done1 = done; r_busy1 = busy; r_tail1 = tail_ones;
            end
            if (c > 0 && done) begin
                r_done = c;
                break;
            end
            if (ccff_shift) begin
                if (r_nsh < 66) r_bits[65-r_nsh] = ccff_head;
                if (r_first < 0) r_first = c;
                r_last = c;
                r_nsh++;
            end else if (r_first >= 0) begin
                r_bub++;
            end
            if (idx >= 9 && in_ready) r_rdy_late++;
            if (idx == 3 && gapc < gap_len && in_ready) gapc++;
            if (in_valid && in_ready) idx++;
            if (c == stop_cyc) return;
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; s_valid = 1'b1;
        #12;
        ntests++; if ({in_ready, ccff_head, ccff_shift, busy, done} !== 5'b0) begin
            nfail++; $display("FAIL rst_outs: got %b required 00000", {in_ready, ccff_head, ccff_shift, busy, done}); end
        ntests++; if (tail_ones !== 16'd0) begin
            nfail++; $display("FAIL rst_tail: got %0d required 0", tail_ones); end
        #11 pReset = 1'b1;
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        ntests++; if ({in_ready, ccff_head, ccff_shift, busy, done} !== 5'b0) begin
            nfail++; $display("FAIL post_rst_outs: got %b required 00000", {in_ready, ccff_head, ccff_shift, busy, done}); end
        ntests++; if ({s_ready, s_shift, s_busy, s_done} !== 4'b0) begin
            nfail++; $display("FAIL post_rst_outs8: got %b required 0000", {s_ready, s_shift, s_busy, s_done}); end
        in_valid = 1'b0; s_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_load(0, -1, -1);
        ntests++; if (r_first !== 2) begin nfail++; $display("FAIL basic_first_shift: got %0d required 2", r_first); end
        ntests++; if (r_last !== 67) begin nfail++; $display("FAIL basic_last_shift: got %0d required 67", r_last); end
        ntests++; if (r_nsh !== 66) begin nfail++; $display("FAIL basic_nshift: got %0d required 66", r_nsh); end
        ntests++; if (r_bub !== 0) begin nfail++; $display("FAIL basic_bubbles: got %0d required 0", r_bub); end
        ntests++; if (r_bits !== exp_bits) begin nfail++; $display("FAIL basic_bits: got %h required %h", r_bits, exp_bits); end
        ntests++; if (r_done !== 68) begin nfail++; $display("FAIL basic_done_cyc: got %0d required 68", r_done); end
        ntests++; if (r_rdy_late !== 0) begin nfail++; $display("FAIL basic_ready_after_last: got %0d required 0", r_rdy_late); end
        ntests++; if (in_ready !== 1'b0 || ccff_shift !== 1'b0) begin
            nfail++; $display("FAIL basic_done_quiet: got ready=%b shift=%b required 0 0", in_ready, ccff_shift); end
    endtask

    task automatic test_starve();
        run_load(5, -1, -1);
        ntests++; if (r_bub !== 5) begin nfail++; $display("FAIL starve_bubbles: got %0d required 5", r_bub); end
        ntests++; if (r_nsh !== 66) begin nfail++; $display("FAIL starve_nshift: got %0d required 66", r_nsh); end
        ntests++; if (r_bits !== exp_bits) begin nfail++; $display("FAIL starve_bits: got %h required %h", r_bits, exp_bits); end
        ntests++; if (r_done !== 73) begin nfail++; $display("FAIL starve_done_cyc: got %0d required 73", r_done); end
    endtask

    task automatic test_start_in_load();
        run_load(0, 20, -1);
        ntests++; if (r_nsh !== 66) begin nfail++; $display("FAIL midstart_nshift: got %0d required 66", r_nsh); end
        ntests++; if (r_bits !== exp_bits) begin nfail++; $display("FAIL midstart_bits: got %h required %h", r_bits, exp_bits); end
        ntests++; if (r_done !== 68) begin nfail++; $display("FAIL midstart_done_cyc: got %0d required 68", r_done); end
    endtask

    task automatic test_tail_ones();
        preload(1'b1);
        run_load(0, -1, -1);
        ntests++; if (tail_ones !== 16'd66) begin nfail++; $display("FAIL tail_ones_all1: got %0d required 66", tail_ones); end
        preload(1'b0);
        run_load(0, -1, -1);
        ntests++; if (r_done1 !== 1'b0) begin nfail++; $display("FAIL restart_done_fall: got %b required 0", r_done1); end
        ntests++; if (r_busy1 !== 1'b1) begin nfail++; $display("FAIL restart_busy: got %b required 1", r_busy1); end
        ntests++; if (r_tail1 !== 16'd0) begin nfail++; $display("FAIL restart_tail_clr: got %0d required 0", r_tail1); end
        ntests++; if (r_first !== 2) begin nfail++; $display("FAIL restart_first_shift: got %0d required 2", r_first); end
        ntests++; if (tail_ones !== 16'd0) begin nfail++; $display("FAIL tail_ones_all0: got %0d required 0", tail_ones); end
    endtask

    task automatic test_reset_mid_load();
        run_load(0, -1, 30);
        ntests++; if (busy !== 1'b1) begin nfail++; $display("FAIL midrst_busy_before: got %b required 1", busy); end
        #1 pReset = 1'b0;
        #1;
        ntests++; if ({in_ready, ccff_head, ccff_shift, busy, done} !== 5'b0) begin
            nfail++; $display("FAIL midrst_outs: got %b required 00000", {in_ready, ccff_head, ccff_shift, busy, done}); end
        ntests++; if (tail_ones !== 16'd0) begin nfail++; $display("FAIL midrst_tail: got %0d required 0", tail_ones); end
        @(posedge prog_clk); #3;
        pReset = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge prog_clk);
        ntests++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            nfail++; $display("FAIL midrst_idle: got busy=%b ready=%b required 0 0", busy, in_ready); end
        run_load(0, -1, -1);
        ntests++; if (r_bits !== exp_bits) begin nfail++; $display("FAIL midrst_reload_bits: got %h required %h", r_bits, exp_bits); end
        ntests++; if (r_done !== 68) begin nfail++; $display("FAIL midrst_reload_done: got %0d required 68", r_done); end
    endtask

    task automatic test_short_chain();
        int acc, n, first, last, dc;
        logic [7:0] bits;
        acc = 0; n = 0; first = -1; last = -1; dc = -1; bits = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge prog_clk); #1;
            s_start = (c == 0); s_valid = 1'b1; s_word = 8'hA5;
            @(negedge prog_clk);
            if (c > 0 && s_done) begin dc = c; break; end
            if (s_valid && s_ready) acc++;
            if (s_shift) begin
                if (n < 8) bits[7-n] = s_head;
                if (first < 0) first = c;
                last = c;
                n++;
            end
        end
        s_start = 1'b0; s_valid = 1'b0;
        ntests++; if (acc !== 1) begin nfail++; $display("FAIL short_accepts: got %0d required 1", acc); end
        ntests++; if (n !== 8) begin nfail++; $display("FAIL short_nshift: got %0d required 8", n); end
        ntests++; if (bits !== 8'hA5) begin nfail++; $display("FAIL short_bits: got %h required a5", bits); end
        ntests++; if (first !== 2 || last !== 9) begin nfail++; $display("FAIL short_window: got %0d..%0d required 2..9", first, last); end
        ntests++; if (dc !== 10) begin nfail++; $display("FAIL short_done_cyc: got %0d required 10", dc); end
    endtask

    initial begin
        exp_bits = cat_bits[71:6];
        test_reset();
        test_basic();
        test_starve();
        test_start_in_load();
        test_tail_ones();
        test_reset_mid_load();
        test_short_chain();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
